// File: rtl/if_fetch.sv
// if_fetch: program counter, instruction memory addressing and IF/ID register with stall, redirect and halt
module if_fetch #(
    parameter int AW = 16,
    parameter int IW = 32,
    parameter int MEM_DEPTH = 1024,
    parameter logic [IW-1:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] imem_addr,
    output logic          imem_wen,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] pc_out,
    output logic          valid_out,
    output logic          halted,
    output logic [CW-1:0] fetch_count
);
    localparam logic [AW-1:0] MASK = AW'(MEM_DEPTH - 1);
    typedef enum logic {RUN, HALTED} state_t;
    state_t        state_q;
    logic [AW-1:0] pc_q, pc_inc, rpc, pc_out_q;
    logic [IW-1:0] instr_q;
    logic          valid_q, halted_q;
    logic [CW-1:0] cnt_q;
    assign pc_inc = (pc_q + AW'(1)) & MASK;
    assign rpc = redirect_pc & MASK;
    assign imem_wen = 1'b0;
    assign instr_out = instr_q;
    assign pc_out = pc_out_q;
    assign valid_out = valid_q;
    assign halted = halted_q;
    assign fetch_count = cnt_q;
    // Address the memory so that next cycle's rdata matches the next pc
    always_comb begin
        imem_addr = rst ? '0 : redirect_valid ? rpc : (stall || state_q == HALTED) ? pc_q : pc_inc;
    end
    // Fetch FSM: redirect beats stall, stall freezes everything, halt stops capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else if (redirect_valid) begin
            state_q  <= RUN;
            pc_q     <= rpc;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (stall) begin
            halted_q <= state_q == HALTED;
        end else if (state_q == HALTED) begin
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            instr_q  <= imem_rdata;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            cnt_q    <= cnt_q + CW'(1);
            pc_q     <= pc_inc;
            if (imem_rdata == HALT_INSTR) state_q <= HALTED;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized and directed check of if_fetch against a behavioural fetch model
module tb_if_fetch;
    localparam int D = 1024;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] A = 32'hA000_000A, B = 32'hB000_000B, C = 32'hC000_000C, DD = 32'hD000_000D;
    logic clk = 0, rst = 1, stall = 0, redirect_valid = 0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] imem_addr, pc_out, raddr;
    logic imem_wen, valid_out, halted;
    logic [31:0] imem_rdata, instr_out, fetch_count;
    logic [31:0] mem [D];
    int m_pc, e_pc, total, bad;
    logic [31:0] e_instr, e_cnt;
    bit e_valid, e_halted, m_halt;

    if_fetch dut (.clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
                  .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_wen(imem_wen),
                  .imem_rdata(imem_rdata), .instr_out(instr_out), .pc_out(pc_out),
                  .valid_out(valid_out), .halted(halted), .fetch_count(fetch_count));

    always #5 clk = ~clk;
    always @(posedge clk) raddr <= rst ? 16'd0 : imem_addr;
    assign imem_rdata = mem[raddr % D];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("valid_out", 64'(valid_out), 64'(e_valid));
        chk("halted", 64'(halted), 64'(e_halted));
        chk("fetch_count", 64'(fetch_count), 64'(e_cnt));
        chk("instr_out", 64'(instr_out), 64'(e_instr));
        chk("pc_out", 64'(pc_out), 64'(e_pc));
        chk("imem_wen", 64'(imem_wen), 64'd0);
    endtask

    // One cycle: drive inputs, check address, advance model on the edge, compare outputs
    task automatic step(input bit r, input bit s, input bit rv, input logic [15:0] rp);
        int ea;
        bit was_halt;
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        ea = r ? 0 : rv ? int'(rp) % D : (m_halt || s) ? m_pc : (m_pc + 1) % D;
        #1 chk("imem_addr", 64'(imem_addr), 64'(ea));
        @(posedge clk);
        was_halt = m_halt;
        if (r) begin
            m_pc = 0; e_instr = 0; e_pc = 0; e_valid = 0; e_halted = 0; e_cnt = 0; m_halt = 0;
        end else if (rv) begin
            m_pc = int'(rp) % D; e_valid = 0; e_halted = 0; m_halt = 0;
        end else begin
            e_halted = was_halt;
            if (!s && was_halt) e_valid = 0;
            else if (!s) begin
                e_instr = mem[m_pc]; e_pc = m_pc; e_valid = 1; e_cnt++;
                m_pc = (m_pc + 1) % D;
                m_halt = (e_instr == HALT);
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h0;
        end
        mem[0] = A; mem[1] = B; mem[2] = C; mem[3] = DD;
        @(negedge clk);
        step(1, 0, 0, 16'd0);
        step(1, 0, 0, 16'd0);
        chk("rst valid", 64'(valid_out), 64'd0);
        chk("rst instr", 64'(instr_out), 64'd0);
        chk("rst imem_addr", 64'(imem_addr), 64'd0);
        step(0, 0, 0, 16'd0);
        chk("lin pc0", 64'(pc_out), 64'd0);
        chk("lin A", 64'(instr_out), 64'(A));
        step(0, 0, 0, 16'd0);
        chk("lin B", 64'(instr_out), 64'(B));
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 16'd0);
            chk("stall B", 64'(instr_out), 64'(B));
            chk("stall pc", 64'(pc_out), 64'd1);
            chk("stall addr", 64'(imem_addr), 64'd2);
        end
        step(0, 0, 0, 16'd0);
        chk("after stall pc", 64'(pc_out), 64'd2);
        chk("after stall C", 64'(instr_out), 64'(C));
        step(0, 0, 0, 16'd0);
        chk("lin D", 64'(instr_out), 64'(DD));
        chk("lin count", 64'(fetch_count), 64'd4);
        run(2);
        chk("pre redirect pc", 64'(pc_out), 64'd5);
        step(0, 0, 1, 16'h0020);
        chk("redir bubble", 64'(valid_out), 64'd0);
        step(0, 0, 0, 16'd0);
        chk("redir pc", 64'(pc_out), 64'h20);
        chk("redir valid", 64'(valid_out), 64'd1);
        step(0, 1, 1, 16'h0030);
        chk("redir+stall bubble", 64'(valid_out), 64'd0);
        step(0, 0, 0, 16'd0);
        chk("redir+stall pc", 64'(pc_out), 64'h30);
        step(0, 0, 1, 16'(D - 1));
        step(0, 0, 0, 16'd0);
        chk("wrap 1023", 64'(pc_out), 64'd1023);
        step(0, 0, 0, 16'd0);
        chk("wrap 0", 64'(pc_out), 64'd0);
        step(0, 0, 0, 16'd0);
        chk("wrap 1", 64'(pc_out), 64'd1);
        step(0, 0, 1, 16'h0405);
        step(0, 0, 0, 16'd0);
        chk("mask pc", 64'(pc_out), 64'd5);
        mem[2] = HALT;
        step(1, 0, 0, 16'd0);
        run(3);
        chk("halt deliver", 64'(instr_out), 64'(HALT));
        chk("halt valid", 64'(valid_out), 64'd1);
        run(1);
        chk("halted", 64'(halted), 64'd1);
        chk("halted bubble", 64'(valid_out), 64'd0);
        chk("halted count", 64'(fetch_count), 64'd3);
        step(0, 1, 0, 16'd0);
        run(2);
        chk("halted frozen", 64'(fetch_count), 64'd3);
        step(0, 0, 1, 16'd0);
        chk("unhalt", 64'(halted), 64'd0);
        step(0, 0, 0, 16'd0);
        chk("restart A", 64'(instr_out), 64'(A));
        run(4);
        step(0, 1, 0, 16'd0);
        step(1, 1, 0, 16'd0);
        chk("mid rst halted", 64'(halted), 64'd0);
        chk("mid rst count", 64'(fetch_count), 64'd0);
        step(0, 0, 0, 16'd0);
        chk("mid rst restart", 64'(instr_out), 64'(A));
        for (int i = 0; i < D; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(39) == 0) mem[i] = HALT;
        end
        for (int i = 0; i < 4000; i++)
            step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0, 16'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
